// File: rtl/fir_filter_pkg.sv
// fir_filter_pkg: constants and types shared between the FIR filter and the
// I2C coefficient loader (image width, byte count, loader FSM states).
package fir_filter_pkg;

   localparam int NTAPS  = 2;
   localparam int IMG_W  = NTAPS * 16;
   localparam int NBYTES = NTAPS * 2;

   typedef enum logic [2:0] {
      IDLE,
      START_A,
      START_B,
      BIT,
      ACK,
      STOP,
      DONE
   } i2c_master_state_t;

endpackage

// File: rtl/i2c_master_if.sv
// i2c_master_if: request/status handshake between a controller and the
// I2C coefficient loader. The controller uses 'master', the loader 'slave'.
interface i2c_master_if
   import fir_filter_pkg::*;
;
   logic             start_in;
   logic [IMG_W-1:0] data_in;
   logic             busy_out;
   logic             done_out;
   logic             nack_out;

   modport master (output start_in, output data_in,
                   input  busy_out, input  done_out, input nack_out);
   modport slave  (input  start_in, input  data_in,
                   output busy_out, output done_out, output nack_out);
endinterface

// File: rtl/i2c_master_tick.sv
// i2c_master_tick: quarter-SCL-period divider. Emits a one-cycle tick every
// CLK_DIV enabled cycles; 'load' restarts a full period, 'hold' freezes it.
module i2c_master_tick #(
   parameter int CLK_DIV = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic load,
   input  logic hold,
   output logic tick
);
   localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // down-count while enabled, tick and reload on reaching zero
   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (load) begin
         cnt_d = RELOAD;
      end else if (en && !hold) begin
         if (cnt_q == '0) begin
            tick  = 1'b1;
            cnt_d = RELOAD;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   // counter register
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/i2c_master.sv
// i2c_master: write-only I2C initiator that sends START, the whole coefficient
// image MSB first as NBYTES bytes (ACK checked after each), then STOP.
// Optional build macro I2C_MASTER_CLK_STRETCH_EN: SCL is read back and the
// SCL-high quarter waits until the bus really reads high (slave stretching).
module i2c_master
   import fir_filter_pkg::*;
#(
   parameter int CLK_DIV = 8
) (
   input  logic        clk,
   input  logic        rst,
   i2c_master_if.slave ctl,
   inout  wire         scl_inout,
   inout  wire         sda_inout
);
   localparam int BYTE_W = (NBYTES > 2) ? $clog2(NBYTES) : 1;
   localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);

   i2c_master_state_t state_q, state_d;
   logic [1:0]        phase_q, phase_d;
   logic [2:0]        bit_q, bit_d;
   logic [BYTE_W-1:0] byte_q, byte_d;
   logic [IMG_W-1:0]  sr_q, sr_d;
   logic              nack_q, nack_d;
   logic              scl_low_q, scl_low_d;
   logic              sda_low_q, sda_low_d;
   logic              sda_meta_q, sda_sync_q;
   logic              tick, load, run, hold;

   assign run = (state_q != IDLE) && (state_q != DONE);

`ifdef I2C_MASTER_CLK_STRETCH_EN
   logic scl_meta_q, scl_sync_q, q2_phase;

   assign q2_phase = (state_q inside {BIT, ACK, STOP}) && (phase_q == 2'd2);
   // a slave holding SCL low keeps the high quarter from counting
   assign hold = q2_phase && !scl_sync_q;

   // SCL read-back synchronizer
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_meta_q <= 1'b1;
         scl_sync_q <= 1'b1;
      end else begin
         scl_meta_q <= scl_inout;
         scl_sync_q <= scl_meta_q;
      end
   end
`else
   assign hold = 1'b0;
`endif

   i2c_master_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (run),
      .load (load),
      .hold (hold),
      .tick (tick)
   );

   // next state: accept, quarter-phase stepping, bit/byte sequencing, ACK check
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      sr_d    = sr_q;
      nack_d  = nack_q;
      load    = 1'b0;
      unique case (state_q)
         IDLE: if (ctl.start_in) begin
            load    = 1'b1;
            state_d = START_A;
            phase_d = 2'd0;
            bit_d   = 3'd0;
            byte_d  = '0;
            sr_d    = ctl.data_in;
            nack_d  = 1'b0;
         end
         START_A: if (tick) begin
            state_d = START_B;
            phase_d = 2'd0;
         end
         START_B: if (tick) begin
            if (phase_q == 2'd1) begin
               state_d = BIT;
               phase_d = 2'd0;
            end else begin
               phase_d = phase_q + 2'd1;
            end
         end
         BIT: if (tick) begin
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'd3) begin
               sr_d  = sr_q << 1;
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = ACK;
            end
         end
         ACK: if (tick) begin
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'd3) begin
               if (sda_sync_q) begin
                  nack_d  = 1'b1;
                  state_d = STOP;
               end else if (byte_q == LAST_BYTE) begin
                  state_d = STOP;
               end else begin
                  byte_d  = byte_q + 1'b1;
                  state_d = BIT;
               end
            end
         end
         STOP: if (tick) begin
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'd3) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // line drive: SCL follows the next state directly; SDA is decoded from the
   // current state so it moves one clk after SCL has gone low
   always_comb begin
      scl_low_d = 1'b0;
      unique case (state_d)
         BIT, ACK: scl_low_d = (phase_d < 2'd2);
         STOP:     scl_low_d = (phase_d == 2'd0);
         default:  scl_low_d = 1'b0;
      endcase
      sda_low_d = 1'b0;
      unique case (state_q)
         START_B: sda_low_d = 1'b1;
         BIT:     sda_low_d = !sr_q[IMG_W-1];
         STOP:    sda_low_d = (phase_q < 2'd2);
         default: sda_low_d = 1'b0;
      endcase
   end

   // state, datapath, line drivers and SDA synchronizer
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         phase_q    <= 2'd0;
         bit_q      <= 3'd0;
         byte_q     <= '0;
         sr_q       <= '0;
         nack_q     <= 1'b0;
         scl_low_q  <= 1'b0;
         sda_low_q  <= 1'b0;
         sda_meta_q <= 1'b1;
         sda_sync_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         bit_q      <= bit_d;
         byte_q     <= byte_d;
         sr_q       <= sr_d;
         nack_q     <= nack_d;
         scl_low_q  <= scl_low_d;
         sda_low_q  <= sda_low_d;
         sda_meta_q <= sda_inout;
         sda_sync_q <= sda_meta_q;
      end
   end

   // open-drain: only ever pull low or release
   assign scl_inout = scl_low_q ? 1'b0 : 1'bz;
   assign sda_inout = sda_low_q ? 1'b0 : 1'bz;

   assign ctl.busy_out = run;
   assign ctl.done_out = (state_q == DONE);
   assign ctl.nack_out = nack_q;

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: table of frames (data, per-byte slave ACK pattern, expected
// bytes/NACK/latency) plus hand sequences for re-pulse, mid-frame reset and,
// when I2C_MASTER_CLK_STRETCH_EN is defined, slave clock stretching.
module tb_i2c_master;

   localparam int CLK_DIV = 4;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  ackm;   // bit i set: slave ACKs byte i
      int          nsent;  // bytes that reach the bus
      logic        nack;
      int          lat;    // accept-to-done cycles
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   wire  scl_bus, sda_bus;

   i2c_master_if ifc ();

   i2c_master #(.CLK_DIV(CLK_DIV)) dut (
      .clk       (clk),
      .rst       (rst),
      .ctl       (ifc),
      .scl_inout (scl_bus),
      .sda_inout (sda_bus)
   );

   pullup (scl_bus);
   pullup (sda_bus);

   logic slv_scl_low = 1'b0;
   logic slv_sda_low = 1'b0;
   assign scl_bus = slv_scl_low ? 1'b0 : 1'bz;
   assign sda_bus = slv_sda_low ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // bus monitor and slave model
   logic       prv_scl = 1'b1, prv_sda = 1'b1, cur_scl, cur_sda;
   logic [7:0] msh = 8'h00;
   logic [7:0] mbyte [8];
   logic       mack  [8];
   int         nbytes = 0, mbit = 0, starts = 0, stops = 0, rises = 0, dones = 0;
   int         str_cnt = 0;
   logic [3:0] slv_ack_mask = 4'hF;
   bit         stretch_en = 1'b0, stretched = 1'b0;

   always @(negedge clk) begin
      cur_scl = (scl_bus !== 1'b0);
      cur_sda = (sda_bus !== 1'b0);
      if (ifc.done_out) dones++;
      if (prv_scl && cur_scl && (prv_sda != cur_sda)) begin
         if (!cur_sda) begin
            starts++;
            nbytes = 0;
            mbit = 0;
            slv_sda_low = 1'b0;
         end else begin
            stops++;
         end
      end else if (!prv_scl && cur_scl) begin
         rises++;
         if (mbit < 8) begin
            msh = {msh[6:0], cur_sda};
            mbit++;
         end else begin
            if (nbytes < 8) begin
               mbyte[nbytes] = msh;
               mack[nbytes]  = cur_sda;
            end
            nbytes++;
            mbit = 0;
         end
      end else if (prv_scl && !cur_scl) begin
         if (slv_sda_low) slv_sda_low = 1'b0;
         else if (mbit == 8 && nbytes < 4 && slv_ack_mask[nbytes]) slv_sda_low = 1'b1;
         if (stretch_en && !stretched && nbytes == 0 && mbit == 4) begin
            slv_scl_low = 1'b1;
            str_cnt = 50;
            stretched = 1'b1;
         end
      end
      if (slv_scl_low) begin
         if (str_cnt == 0) slv_scl_low = 1'b0;
         else str_cnt--;
      end
      prv_scl = cur_scl;
      prv_sda = cur_sda;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // run one frame and check everything the bus and the status outputs show
   task automatic do_vec(input vec_t v, input bit repulse, input string tag, output int lat);
      bit seen, pulsed;
      @(posedge clk); #1;
      starts = 0; stops = 0; rises = 0; dones = 0;
      stretched = 1'b0;
      slv_ack_mask = v.ackm;
      ifc.data_in  = v.data;
      ifc.start_in = 1'b1;
      @(posedge clk); #1;
      ifc.start_in = 1'b0;
      ifc.data_in  = 32'h0;
      chk({tag, ".busy_on_accept"}, ifc.busy_out, 1);
      chk({tag, ".nack_cleared"}, ifc.nack_out, 0);
      lat = 0; seen = 1'b0; pulsed = 1'b0;
      while (!seen && lat < 4000) begin
         @(negedge clk); #1;
         lat++;
         if (ifc.start_in) ifc.start_in = 1'b0;
         if (repulse && !pulsed && nbytes == 0 && mbit == 3 && starts == 1) begin
            ifc.data_in  = 32'h5A5A_5A5A;
            ifc.start_in = 1'b1;
            pulsed = 1'b1;
         end
         if (ifc.done_out) seen = 1'b1;
      end
      chk({tag, ".done_seen"}, seen, 1);
`ifdef I2C_MASTER_CLK_STRETCH_EN
      chk({tag, ".latency_min"}, (lat >= v.lat), 1);
`else
      chk({tag, ".latency"}, lat, v.lat);
`endif
      repeat (20) @(negedge clk);
      #1;
      chk({tag, ".nbytes"}, nbytes, v.nsent);
      for (int i = 0; i < v.nsent && i < 4; i++) begin
         chk($sformatf("%s.byte%0d", tag, i), mbyte[i], v.data[31-8*i -: 8]);
         chk($sformatf("%s.ack%0d", tag, i), mack[i], !v.ackm[i]);
      end
      chk({tag, ".starts"}, starts, 1);
      chk({tag, ".stops"}, stops, 1);
      chk({tag, ".scl_rises"}, rises, 9 * v.nsent + 1);
      chk({tag, ".done_count"}, dones, 1);
      chk({tag, ".nack_sticky"}, ifc.nack_out, v.nack);
      chk({tag, ".busy_after"}, ifc.busy_out, 0);
   endtask

   vec_t vt [6];
   int   lat, w;

   initial begin
      vt[0] = '{32'hA5C3_0F81, 4'b1111, 4, 1'b0, 605};
      vt[1] = '{32'hA5C3_0F81, 4'b1101, 2, 1'b1, 317};
      vt[2] = '{32'h0000_0000, 4'b1111, 4, 1'b0, 605};
      vt[3] = '{32'hFFFF_FFFF, 4'b1111, 4, 1'b0, 605};
      vt[4] = '{32'h8000_0001, 4'b1110, 1, 1'b1, 173};
      vt[5] = '{32'h1234_5678, 4'b0111, 4, 1'b1, 605};

      ifc.start_in = 1'b0;
      ifc.data_in  = 32'h0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset.busy", ifc.busy_out, 0);
      chk("reset.done", ifc.done_out, 0);
      chk("reset.nack", ifc.nack_out, 0);
      chk("reset.scl", (scl_bus !== 1'b0), 1);
      chk("reset.sda", (sda_bus !== 1'b0), 1);
      rst = 1'b0;
      repeat (5) @(posedge clk);

      for (int k = 0; k < 6; k++) do_vec(vt[k], 1'b0, $sformatf("vec%0d", k), lat);

      // start_in during byte 1 must not disturb the frame
      do_vec(vt[0], 1'b1, "repulse", lat);

      // reset in the middle of byte 3, then a clean frame
      @(posedge clk); #1;
      starts = 0;
      slv_ack_mask = 4'hF;
      ifc.data_in  = 32'hA5C3_0F81;
      ifc.start_in = 1'b1;
      @(posedge clk); #1;
      ifc.start_in = 1'b0;
      w = 0;
      while (!(starts == 1 && nbytes == 2 && mbit == 3) && w < 3000) begin
         @(negedge clk); #1;
         w++;
      end
      chk("midrst.reached", (w < 3000), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst.scl", (scl_bus !== 1'b0), 1);
      chk("midrst.sda", (sda_bus !== 1'b0), 1);
      chk("midrst.busy", ifc.busy_out, 0);
      chk("midrst.done", ifc.done_out, 0);
      repeat (20) @(posedge clk);
      do_vec(vt[0], 1'b0, "postrst", lat);

`ifdef I2C_MASTER_CLK_STRETCH_EN
      stretch_en = 1'b1;
      do_vec(vt[0], 1'b0, "stretch", lat);
      stretch_en = 1'b0;
      chk("stretch.applied", stretched, 1);
      chk("stretch.delay", (lat >= vt[0].lat + 40), 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
